ped_request_conditioner: RTL

- Upstream stage of traffic_light_controller; drives its ped_request input.
- Takes a raw, asynchronous, bouncy pedestrian push-button and synchronises and debounces it.
- Latches a single pending request and holds ped_request high until the controller serves it, i.e. until ped_light pulses.
- Applies a cooldown after each service so a held or re-pressed button cannot immediately re-trigger a walk phase.

---
 rtl/traffic_pkg.sv | 30 +++
 rtl/button_debouncer.sv | 68 ++++++
 rtl/ped_request_conditioner.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module : traffic_pkg
// Purpose: Shared types and default constants for the pedestrian request
//          path feeding traffic_light_controller.
//          - state_e            : request FSM state encoding (2 bits)
//          - DEBOUNCE_CYCLES_DEF: default debounce length in clock cycles
//          - COOLDOWN_CYCLES_DEF: default post-service cooldown in cycles
//          - cnt_width()        : counter width able to hold 0..n-1
// Rev    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_SERVING  = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int COOLDOWN_CYCLES_DEF = 8;

    // Width of a down/up counter that must represent values 0..n-1 (n >= 1).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module : button_debouncer
// Purpose: Two-flop synchroniser, level debouncer and rising-edge detector
//          for a raw mechanical push-button.
// Ports  : clk          in   system clock, rising edge
//          rst_n        in   asynchronous active-low reset
//          button_raw_i in   raw button level, asynchronous to clk
//          btn_filt_o   out  debounced button level
//          press_o      out  one-cycle pulse on each debounced rising edge
// Rev    : 1.0  initial release
// ============================================================================
module button_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_raw_i,
    output logic btn_filt_o,
    output logic press_o
);

    localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            filt_q, filt_d;
    logic            filt_prev_q;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any agreement restarts it, so a glitch must persist
    // for DEBOUNCE_CYCLES consecutive samples to be accepted.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == DB_LAST) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= button_raw_i;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            cnt_q       <= cnt_d;
        end
    end

    assign btn_filt_o = filt_q;
    assign press_o    = filt_q & ~filt_prev_q;

endmodule : button_debouncer
`default_nettype wire

// File: rtl/ped_request_conditioner.sv
`default_nettype none
// ============================================================================
// Module : ped_request_conditioner
// Purpose: Conditions a raw pedestrian push-button into a single latched
//          request for traffic_light_controller, holds it until the walk
//          light is served, then enforces a cooldown. A press seen during
//          service or cooldown is carried and re-issued when cooldown ends.
// Ports  : clk          in   system clock, rising edge
//          reset        in   asynchronous active-low reset
//          button_raw   in   raw push-button level (async, active-high)
//          ped_light    in   walk indication from the controller
//          ped_request  out  registered request to the controller
//          wait_led     out  registered "request accepted, waiting" lamp
//          press_count  out  saturating accepted-press counter [CNT_W]
//                            (only with PED_PRESS_CNT_EN)
// Config : `define PED_PRESS_CNT_EN adds the CNT_W parameter and press_count.
// Rev    : 1.0  initial release
// ============================================================================
module ped_request_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF
`ifdef PED_PRESS_CNT_EN
    ,
    parameter int CNT_W           = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_raw,
    input  logic             ped_light,
    output logic             ped_request,
    output logic             wait_led
`ifdef PED_PRESS_CNT_EN
    ,
    output logic [CNT_W-1:0] press_count
`endif
);

    localparam int              CD_W    = cnt_width(COOLDOWN_CYCLES);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);

    logic            btn_filt;
    logic            press_raw;
    logic            press;
    state_e          state_q, state_d;
    logic            carry_q, carry_d;
    logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;
    logic            ped_request_q, ped_request_d;
    logic            wait_led_q, wait_led_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk          (clk),
        .rst_n        (reset),
        .button_raw_i (button_raw),
        .btn_filt_o   (btn_filt),
        .press_o      (press_raw)
    );

    // A press edge can only occur with the filtered level high; qualifying
    // with it keeps the FSM immune to any edge-detector/level skew.
    assign press = press_raw & btn_filt;

    always_comb begin
        state_d  = state_q;
        carry_d  = carry_q;
        cd_cnt_d = cd_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // Presses while already pending are absorbed, except one
                // landing on the service edge, which is remembered.
                if (ped_light) begin
                    state_d = ST_SERVING;
                    if (press) begin
                        carry_d = 1'b1;
                    end
                end
            end
            ST_SERVING: begin
                if (press) begin
                    carry_d = 1'b1;
                end
                if (!ped_light) begin
                    state_d  = ST_COOLDOWN;
                    cd_cnt_d = CD_LOAD;
                end
            end
            ST_COOLDOWN: begin
                if (press) begin
                    carry_d = 1'b1;
                end
                if (cd_cnt_q == '0) begin
                    // A press on the expiry cycle itself still counts.
                    if (carry_q || press) begin
                        state_d = ST_PENDING;
                        carry_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cd_cnt_d = cd_cnt_q - CD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they move on the
        // same edge as the state register.
        ped_request_d = (state_d == ST_PENDING);
        wait_led_d    = ped_request_d ||
                        (((state_d == ST_SERVING) || (state_d == ST_COOLDOWN)) && carry_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            carry_q       <= 1'b0;
            cd_cnt_q      <= '0;
            ped_request_q <= 1'b0;
            wait_led_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            carry_q       <= carry_d;
            cd_cnt_q      <= cd_cnt_d;
            ped_request_q <= ped_request_d;
            wait_led_q    <= wait_led_d;
        end
    end

    assign ped_request = ped_request_q;
    assign wait_led    = wait_led_q;

`ifdef PED_PRESS_CNT_EN
    // A press is "accepted" when it either opens a request or sets carry;
    // the only press that does neither is one while PENDING without service.
    logic             press_accept;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

    assign press_accept = press && ((state_q != ST_PENDING) || ped_light);

    always_comb begin
        press_cnt_d = press_cnt_q;
        if (press_accept && (press_cnt_q != '1)) begin
            press_cnt_d = press_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_cnt_q <= '0;
        end else begin
            press_cnt_q <= press_cnt_d;
        end
    end

    assign press_count = press_cnt_q;
`endif

endmodule : ped_request_conditioner
`default_nettype wire
